row_pattern_generator: RTL

Parametrised row pattern source for the HUB-75 display path: on each `start` it writes one scan row of test-pattern pixels (top and bottom panel halves packed per word) into the double-banked line buffer. It supersedes the fixed 64-pixel generator with configurable row width, row count and colour depth, a selectable pattern mode, and a write back-pressure handshake. It sits between the frame/row sequencer (which issues `start`, `y`, `frame_count`, `mode`) and the line-buffer write port.

---
 rtl/row_pattern_generator_if.sv | 26 ++
 rtl/row_pattern_generator.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/row_pattern_generator_if.sv
// Line-buffer write port between the row pattern generator and the buffer.
// master: drives write_address / write_data / write_enable, samples write_ready.
// slave : the line buffer, which drives write_ready.
interface row_pattern_generator_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 48
);
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic              write_ready;

  modport master (
    output write_address,
    output write_data,
    output write_enable,
    input  write_ready
  );

  modport slave (
    input  write_address,
    input  write_data,
    input  write_enable,
    output write_ready
  );
endinterface

// File: rtl/row_pattern_generator.sv
// Row pattern source for the HUB-75 path: on start, writes one scan row of
// test-pattern pixels (top and bottom halves per word) into the line buffer.
// Ports:
//   clock, reset_n          - clock, async active-low reset
//   start, y, frame_count,  - row request and its parameters (captured on start)
//   mode
//   is_idle, done           - idle flag, one-cycle end-of-row pulse
//   wr (master)             - write_address {bank, x}, write_data, write_enable,
//                             write_ready back-pressure
module row_pattern_generator #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ROW_BITS   = 5,
  parameter int unsigned COLOR_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ROW_BITS-1:0]     y,
  input  logic [9:0]              frame_count,
  input  logic [2:0]              mode,
  output logic                    is_idle,
  output logic                    done,
  row_pattern_generator_if.master wr
);

  localparam int unsigned XW  = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW  = ROW_BITS + 1;
  // Common compare width; at least 4 so bit 3 exists (missing bits read 0).
  localparam int unsigned EW0 = (XW > RW) ? XW : RW;
  localparam int unsigned EW  = (EW0 > 4) ? EW0 : 4;
  // Sum width wide enough that the low COLOR_BITS of x + frame_count are exact.
  localparam int unsigned SW0 = (EW > 10) ? EW : 10;
  localparam int unsigned SW  = ((SW0 > COLOR_BITS) ? SW0 : COLOR_BITS) + 1;
  localparam int unsigned PW  = 3 * COLOR_BITS;

  typedef enum logic [1:0] {
    kWait = 2'd0,
    kRun  = 2'd1,
    kDone = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [ROW_BITS-1:0] y_q, y_d;
  logic [9:0]          fc_q, fc_d;
  logic [2:0]          mode_q, mode_d;
  logic                we;

  // State and captured request registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= kWait;
      x_q     <= '0;
      y_q     <= '0;
      fc_q    <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; write_enable is implied by kRun, so acceptance is just write_ready
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fc_d    = fc_q;
    mode_d  = mode_q;
    unique case (state_q)
      kWait: begin
        if (start) begin
          y_d     = y;
          fc_d    = frame_count;
          mode_d  = mode;
          x_d     = '0;
          state_d = kRun;
        end
      end
      kRun: begin
        if (wr.write_ready) begin
          if (x_q == XW'(WIDTH - 1)) begin
            state_d = kDone;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      kDone: state_d = kWait;
      default: state_d = kWait;
    endcase
  end

  // One half's {R, G, B} for column xe, panel row re
  function automatic logic [PW-1:0] pixel(input logic [EW-1:0] xe,
                                          input logic [EW-1:0] re,
                                          input logic [9:0]    fc,
                                          input logic [2:0]    md);
    logic [COLOR_BITS-1:0] f, r, g, b;
    f = '1;
    r = '0;
    g = '0;
    b = '0;
    case (md)
      3'd0: begin
        r = xe[0] ? f : '0;
        g = xe[1] ? f : '0;
        b = xe[2] ? f : '0;
      end
      3'd1: begin
        if (xe <= re) begin
          r = f;
          g = f;
          b = f;
        end
      end
      3'd2: begin
        r = COLOR_BITS'(SW'(xe) + SW'(fc));
        g = COLOR_BITS'(re);
      end
      3'd3: begin
        if (xe[3] ^ re[3] ^ fc[5]) begin
          r = f;
          g = f;
          b = f;
        end
      end
      default: ;
    endcase
    return {r, g, b};
  endfunction

  logic [EW-1:0] x_ext, r_top, r_bot;

  // Bottom-half row is y + 2^ROW_BITS, i.e. y with the extra top bit set
  assign x_ext = EW'(x_q);
  assign r_top = EW'({1'b0, y_q});
  assign r_bot = EW'({1'b1, y_q});

  assign we              = (state_q == kRun);
  assign is_idle         = (state_q == kWait);
  assign done            = (state_q == kDone);
  assign wr.write_enable = we;
  assign wr.write_address = {fc_q[0], x_q};
  assign wr.write_data   = we ? {pixel(x_ext, r_top, fc_q, mode_q),
                                 pixel(x_ext, r_bot, fc_q, mode_q)} : '0;

endmodule
